// File: rtl/uart_rx_ascii_if.sv
// Character stream from the UART receiver to the sequence verifier, plus the serial line feeding it.
interface uart_rx_ascii_if;
  logic       rx;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       frame_error;
  logic       busy;

  modport master (
    input  rx,
    output ascii_char,
    output char_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  ascii_char,
    input  char_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver: deserialises rx into ascii_char with a one-cycle char_valid strobe,
// flags bad stop bits on frame_error and refuses to restart until the line returns high.
module uart_rx_ascii #(
  parameter int unsigned UART_RX_BAUD = 20,
  parameter int unsigned freq         = 200
) (
  input logic             clk,
  input logic             rst,
  uart_rx_ascii_if.master bus
);

  localparam int unsigned CPB  = freq / UART_RX_BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitn_q;
  logic [7:0]    shift_q;
  logic [7:0]    ascii_q;
  logic          char_valid_q;
  logic          frame_error_q;
  logic          busy_q;

  // Sync flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      cnt_q         <= '0;
      bitn_q        <= '0;
      shift_q       <= '0;
      ascii_q       <= '0;
      char_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_meta_q     <= bus.rx;
      rx_s_q        <= rx_meta_q;
      char_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              bitn_q  <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == CW'(CPB - 1)) begin
            cnt_q           <= '0;
            shift_q[bitn_q] <= rx_s_q;
            if (bitn_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bitn_q <= bitn_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (cnt_q == CW'(CPB - 1)) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              ascii_q      <= shift_q;
              char_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // A held-low (break) line must go high before another frame can start.
        WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ascii_char  = ascii_q;
  assign bus.char_valid  = char_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Scoreboard bench for uart_rx_ascii: default build (CPB=10) and a CPB=16 build side by side.
module tb_uart_rx_ascii;

  localparam int CPB0  = 10;
  localparam int HALF0 = 5;
  localparam int CPB1  = 16;

  logic clk;
  logic rst;

  uart_rx_ascii_if if0 ();
  uart_rx_ascii_if if1 ();

  uart_rx_ascii dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  uart_rx_ascii #(
    .UART_RX_BAUD (10),
    .freq         (160)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int cv0 = 0, fe0 = 0, viol0 = 0;
  int cv1 = 0, fe1 = 0, viol1 = 0;
  bit pcv0 = 0, pfe0 = 0, pcv1 = 0, pfe1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) if0.rx = v;
    else            if1.rx = v;
  endtask

  // Drives one frame; expected bytes are pushed before the line is driven.
  task automatic send_frame(input int which, input logic [7:0] b, input bit stop_ok,
                            input bit expect_char, input int max_clks);
    logic [9:0] fr;
    int cpb;
    fr  = {stop_ok, b, 1'b0};
    cpb = (which == 0) ? CPB0 : CPB1;
    if (expect_char && stop_ok) begin
      if (which == 0) q0.push_back(b);
      else            q1.push_back(b);
    end
    for (int i = 0; i < 10 * cpb && i < max_clks; i++) begin
      set_rx(which, fr[i / cpb]);
      @(negedge clk);
    end
  endtask

  // Output monitors: pop expected bytes on char_valid and track strobe rules.
  always @(negedge clk) begin
    if (rst) begin
      if (if0.char_valid) begin
        cv0++;
        if (q0.size() > 0) check("ascii0", 32'(if0.ascii_char), 32'(q0.pop_front()));
        else               check("unexpected_cv0", 32'(if0.char_valid), 32'd0);
      end
      if (if0.frame_error) fe0++;
      if (if0.char_valid && if0.frame_error) viol0++;
      if ((if0.char_valid && pcv0) || (if0.frame_error && pfe0)) viol0++;
      pcv0 = if0.char_valid;
      pfe0 = if0.frame_error;

      if (if1.char_valid) begin
        cv1++;
        if (q1.size() > 0) check("ascii1", 32'(if1.ascii_char), 32'(q1.pop_front()));
        else               check("unexpected_cv1", 32'(if1.char_valid), 32'd0);
      end
      if (if1.frame_error) fe1++;
      if (if1.char_valid && if1.frame_error) viol1++;
      if ((if1.char_valid && pcv1) || (if1.frame_error && pfe1)) viol1++;
      pcv1 = if1.char_valid;
      pfe1 = if1.frame_error;
    end else begin
      pcv0 = 0; pfe0 = 0; pcv1 = 0; pfe1 = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit busy_seen;
    int cv_snap;

    rst    = 1'b0;
    if0.rx = 1'b1;
    if1.rx = 1'b1;
    #1;
    check("rst_ascii", 32'(if0.ascii_char), 32'h00);
    check("rst_cv", 32'(if0.char_valid), 32'd0);
    check("rst_fe", 32'(if0.frame_error), 32'd0);
    check("rst_busy", 32'(if0.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // Single byte at default rate
    send_frame(0, 8'h31, 1'b1, 1'b1, 10000);
    repeat (20) @(negedge clk);
    check("t1_cv_count", 32'(cv0), 32'd1);
    check("t1_fe_count", 32'(fe0), 32'd0);
    check("t1_ascii", 32'(if0.ascii_char), 32'h31);
    check("t1_busy", 32'(if0.busy), 32'd0);

    // Back-to-back "123+X"
    send_frame(0, 8'h31, 1'b1, 1'b1, 10000);
    send_frame(0, 8'h32, 1'b1, 1'b1, 10000);
    send_frame(0, 8'h33, 1'b1, 1'b1, 10000);
    send_frame(0, 8'h2B, 1'b1, 1'b1, 10000);
    send_frame(0, 8'h58, 1'b1, 1'b1, 10000);
    repeat (20) @(negedge clk);
    check("t2_cv_count", 32'(cv0), 32'd6);
    check("t2_fe_count", 32'(fe0), 32'd0);
    check("t2_ascii", 32'(if0.ascii_char), 32'h58);

    // Short glitch on the line
    busy_seen = 0;
    if0.rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if0.busy) busy_seen = 1;
    end
    if0.rx = 1'b1;
    for (int i = 0; i < HALF0 + 2; i++) begin
      @(negedge clk);
      if (if0.busy) busy_seen = 1;
    end
    check("t3_busy_seen", 32'(busy_seen), 32'd1);
    check("t3_busy_idle", 32'(if0.busy), 32'd0);
    repeat (10) @(negedge clk);
    check("t3_cv_count", 32'(cv0), 32'd6);
    check("t3_fe_count", 32'(fe0), 32'd0);

    // Bad stop bit followed by a held-low line
    send_frame(0, 8'h41, 1'b0, 1'b1, 10000);
    if0.rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_fe_count", 32'(fe0), 32'd1);
    check("t4_cv_count", 32'(cv0), 32'd6);
    check("t4_ascii_hold", 32'(if0.ascii_char), 32'h58);
    check("t4_busy_break", 32'(if0.busy), 32'd1);
    if0.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_busy_release", 32'(if0.busy), 32'd0);
    check("t4_cv_after_break", 32'(cv0), 32'd6);
    send_frame(0, 8'h42, 1'b1, 1'b1, 10000);
    repeat (20) @(negedge clk);
    check("t4_cv_count2", 32'(cv0), 32'd7);
    check("t4_ascii", 32'(if0.ascii_char), 32'h42);
    check("t4_fe_count2", 32'(fe0), 32'd1);

    // Asynchronous reset inside data bit 4 of 0x55
    send_frame(0, 8'h55, 1'b1, 1'b0, 5 * CPB0 + 5);
    #2;
    rst = 1'b0;
    #1;
    check("t5_ascii", 32'(if0.ascii_char), 32'h00);
    check("t5_cv", 32'(if0.char_valid), 32'd0);
    check("t5_fe", 32'(if0.frame_error), 32'd0);
    check("t5_busy", 32'(if0.busy), 32'd0);
    if0.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    cv_snap = cv0;
    send_frame(0, 8'h2A, 1'b1, 1'b1, 10000);
    repeat (20) @(negedge clk);
    check("t5_cv_count", 32'(cv0 - cv_snap), 32'd1);
    check("t5_ascii_after", 32'(if0.ascii_char), 32'h2A);

    // Alternate build, CPB=16
    send_frame(1, 8'h00, 1'b1, 1'b1, 10000);
    send_frame(1, 8'hFF, 1'b1, 1'b1, 10000);
    send_frame(1, 8'h80, 1'b1, 1'b1, 10000);
    repeat (30) @(negedge clk);
    check("t6_cv_count", 32'(cv1), 32'd3);
    check("t6_fe_count", 32'(fe1), 32'd0);
    check("t6_ascii", 32'(if1.ascii_char), 32'h80);
    check("t6_busy", 32'(if1.busy), 32'd0);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("strobe_rules0", 32'(viol0), 32'd0);
    check("strobe_rules1", 32'(viol1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
